// File: rtl/press_emitter.sv
// press_emitter: turns one-shot short/long press commands into push-button
// waveforms with fixed hold and release times for the press classifier.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   cmd_valid    command request, held by the requester until accepted
//   cmd_long     1 = long press (mode switch), 0 = short press (lamp toggle)
//   cmd_ready    high only while idle (combinational from state)
//   cmd_abort    ends the current press early; the gap still follows
//   push_button  synthesised button level (registered)
//   busy         high while pressing or in the release gap (combinational)
//   done         one-cycle pulse in the first idle cycle after every gap
//
// Optional feature: define PRESS_BOUNCE_EN to replace the first 16 high
// cycles of each press with LFSR noise, emulating contact bounce.
module press_emitter #(
  parameter int unsigned DEBOUNCE_P        = 300,
  parameter int unsigned SWITCH_MODE_MIN_T = 5000,
  parameter int unsigned SHORT_T           = 1000,
  parameter int unsigned LONG_T            = 6000,
  parameter int unsigned GAP_T             = 20,
  parameter int unsigned CNT_W             = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_long,
  output logic cmd_ready,
  input  logic cmd_abort,
  output logic push_button,
  output logic busy,
  output logic done
);

  localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_T - 1);
  localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_T - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(15);

  // Elaboration-time parameter checks
  if ((SHORT_T < DEBOUNCE_P + 10) || (SHORT_T + 10 > SWITCH_MODE_MIN_T)) begin : g_bad_short
    $error("press_emitter: SHORT_T must lie in [DEBOUNCE_P+10, SWITCH_MODE_MIN_T-10]");
  end
  if (LONG_T < SWITCH_MODE_MIN_T + 10) begin : g_bad_long
    $error("press_emitter: LONG_T must be >= SWITCH_MODE_MIN_T+10");
  end
  if (GAP_T < 2) begin : g_bad_gap
    $error("press_emitter: GAP_T must be >= 2");
  end
  if ((64'(SHORT_T) >= CNT_RANGE) || (64'(LONG_T) >= CNT_RANGE) ||
      (64'(GAP_T) >= CNT_RANGE)) begin : g_bad_width
    $error("press_emitter: timing values must fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hold_sel, hold_sel_nx;
  logic             pb_nx, done_nx;
  logic             accept_c;
  logic             press_end_c;
  logic             gap_end_c;
  logic [CNT_W-1:0] hold_lim_c;

  assign accept_c    = cmd_valid && (state == IDLE);
  assign hold_lim_c  = hold_sel ? LONG_LIM : SHORT_LIM;
  // Press leaves early on abort or after the last held cycle
  assign press_end_c = cmd_abort || (cnt == hold_lim_c);
  assign gap_end_c   = (cnt == GAP_LIM);

  assign busy      = (state != IDLE);
  assign cmd_ready = ~busy;

`ifdef PRESS_BOUNCE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb_c;
  logic        bounce_c;

  // Bounce bits are consumed for the first 16 press cycles: one at accept,
  // then while the counter (press cycle - 1) feeds cycles 2..16.
  assign bounce_c  = accept_c ||
                     ((state == PRESS) && !press_end_c && (cnt < BOUNCE_LIM));
  assign lfsr_fb_c = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Fibonacci LFSR, taps 16,14,13,11; never reseeded between commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else if (bounce_c) begin
      lfsr <= {lfsr_fb_c, lfsr[15:1]};
    end
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_sel    <= 1'b0;
      push_button <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      hold_sel    <= hold_sel_nx;
      push_button <= pb_nx;
      done        <= done_nx;
    end
  end

  // Next-state and counter
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hold_sel_nx = hold_sel;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nx    = PRESS;
          cnt_nx      = '0;
          hold_sel_nx = cmd_long;
        end
      end
      PRESS: begin
        if (press_end_c) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_end_c) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    pb_nx   = 1'b0;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
`ifdef PRESS_BOUNCE_EN
        pb_nx = accept_c && lfsr[0];
`else
        pb_nx = accept_c;
`endif
      end
      PRESS: begin
        if (!press_end_c) begin
`ifdef PRESS_BOUNCE_EN
          pb_nx = bounce_c ? lfsr[0] : 1'b1;
`else
          pb_nx = 1'b1;
`endif
        end
      end
      GAP: begin
        done_nx = gap_end_c;
      end
      default: begin
        pb_nx   = 1'b0;
        done_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_press_emitter.sv
// Scoreboard bench for press_emitter: stimulus pushes expected press records
// (hold cycles, gap cycles, start spacing); the monitor measures every press
// and compares on each done pulse.
module tb_press_emitter;

  localparam int SHORT_T = 1000;
  localparam int LONG_T  = 6000;
  localparam int GAP_T   = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_long = 1'b0;
  logic cmd_abort = 1'b0;
  logic cmd_ready;
  logic push_button;
  logic busy;
  logic done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int hi;
    int lo;
    int rise_gap;
  } exp_t;

  exp_t sb[$];

  press_emitter #(
    .DEBOUNCE_P(300),
    .SWITCH_MODE_MIN_T(5000),
    .SHORT_T(SHORT_T),
    .LONG_T(LONG_T),
    .GAP_T(GAP_T),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_long(cmd_long),
    .cmd_ready(cmd_ready),
    .cmd_abort(cmd_abort),
    .push_button(push_button),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: per press, count busy cycles and the index of the last high cycle
  int   ncyc = 0;
  int   bidx = 0;
  int   last_hi = 0;
  int   cur_start = 0;
  int   prev_start = 0;
  bit   prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      bidx      = 0;
      last_hi   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) cur_start = ncyc;
        bidx++;
        if (push_button) last_hi = bidx;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("hold_cycles", last_hi, mon_e.hi);
          check("gap_cycles", bidx - last_hi, mon_e.lo);
          if (mon_e.rise_gap != 0)
            check("press_spacing", cur_start - prev_start, mon_e.rise_gap);
        end
        prev_start = cur_start;
        bidx       = 0;
        last_hi    = 0;
      end
      prev_busy = busy;
    end
  end

  // Called at a negedge while idle; returns at the negedge of press cycle 1
  task automatic start(input bit lng, input bit ab);
    check("ready_before_accept", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_long  = lng;
    cmd_abort = ab;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_long  = 1'b0;
    cmd_abort = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("ready_after_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  function automatic exp_t mk(input int hi, input int lo, input int rg);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.rise_gap = rg;
    return e;
  endfunction

  initial begin
    int k;
    int n;
`ifdef PRESS_BOUNCE_EN
    logic [15:0] model;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_push_button", int'(push_button), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_push_button", int'(push_button), 0);

    // Short press from reset
    sb.push_back(mk(SHORT_T, GAP_T, 0));
    cmd_valid = 1'b1;
    cmd_long  = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("short_busy", int'(busy), 1);
    check("short_ready", int'(cmd_ready), 0);
`ifdef PRESS_BOUNCE_EN
    model = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      check("bounce_bit", int'(push_button), int'(model[0]));
      model = {model[0] ^ model[2] ^ model[3] ^ model[5], model[15:1]};
      @(negedge clk);
    end
    check("bounce_settled_high", int'(push_button), 1);
`else
    check("short_first_high", int'(push_button), 1);
`endif
    wait_done(SHORT_T + GAP_T + 50);
    @(negedge clk);

    // Long press, with a stray cmd_valid pulse while busy that must be ignored
    sb.push_back(mk(LONG_T, GAP_T, 0));
    start(1'b1, 1'b0);
    repeat (100) @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_ignores_valid", int'(busy), 1);
    wait_done(LONG_T + GAP_T + 50);
    @(negedge clk);

    // Back-to-back: cmd_valid held for three short presses
    for (int i = 0; i < 3; i++) sb.push_back(mk(SHORT_T, GAP_T, (i == 0) ? 0 : SHORT_T + GAP_T + 1));
    cmd_valid = 1'b1;
    cmd_long  = 1'b0;
    k = 0;
    n = 0;
    while (k < 3 && n < 4000) begin
      @(negedge clk);
      n++;
      if (done) begin
        k++;
        if (k == 3) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_done_count", k, 3);
    @(negedge clk);

    // Abort a long press at press cycle 400
    sb.push_back(mk(400, GAP_T, 0));
    start(1'b1, 1'b0);
    repeat (399) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("abort_low", int'(push_button), 0);
    check("abort_still_busy", int'(busy), 1);
    wait_done(GAP_T + 50);
    @(negedge clk);

    // Abort coinciding with accept is ignored
    sb.push_back(mk(SHORT_T, GAP_T, 0));
    start(1'b0, 1'b1);
    wait_done(SHORT_T + GAP_T + 50);
    @(negedge clk);

    // Reset mid-press: output drops between clock edges, no done afterwards
    start(1'b0, 1'b0);
    repeat (49) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_push_button", int'(push_button), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", int'(cmd_ready), 1);
    repeat (SHORT_T + 100) @(negedge clk);

    // Recovery press after reset
    sb.push_back(mk(SHORT_T, GAP_T, 0));
    start(1'b0, 1'b0);
    wait_done(SHORT_T + GAP_T + 50);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/press_emitter.md
Name: press_emitter

Overview:
- Synthesises push-button waveforms from one-shot commands: short press (lamp toggle, B path) or long press (mode switch, A path).
- Drives the push_button input of the press classifier. Used by automation sources (sensor/app) and as the bench stimulus generator.
- Guarantees hold and release times that the classifier resolves unambiguously.

Parameters:
- DEBOUNCE_P, 300: classifier debounce window, in cycles; used only for elaboration checks.
- SWITCH_MODE_MIN_T, 5000: classifier long-press threshold, in cycles; used only for elaboration checks.
- SHORT_T, 1000: push_button high time for a short press, in cycles. Required: DEBOUNCE_P+10 <= SHORT_T <= SWITCH_MODE_MIN_T-10.
- LONG_T, 6000: push_button high time for a long press, in cycles. Required: LONG_T >= SWITCH_MODE_MIN_T+10.
- GAP_T, 20: mandatory low time after every press, in cycles. Required: GAP_T >= 2.
- CNT_W, 16: counter width. Required: every timing value < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_long  in  1  command type: 1 = long press, 0 = short press; sampled on accept
- cmd_ready  out  1  high only in IDLE
- cmd_abort  in  1  ends the current press early
- push_button  out  1  synthesised button level, registered
- busy  out  1  high in PRESS or GAP
- done  out  1  single-cycle pulse at the end of every GAP

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, push_button=0, done=0, busy=0.
  - cmd_ready=1 once rst is released.
  - Asserting rst mid-press drops push_button immediately, without waiting for a clock edge.
- Elaboration: any violated parameter constraint is a fatal $error.
- Accept: cmd_valid && cmd_ready at a rising edge. cmd_long is latched into hold_sel.
- FSM state IDLE:
  - cmd_ready=1, busy=0, push_button=0.
  - On accept: go to PRESS, counter=0.
- FSM state PRESS:
  - push_button=1 starting the cycle after accept (latency 1).
  - Counter increments every cycle.
  - After exactly HOLD cycles high (HOLD = hold_sel ? LONG_T : SHORT_T): go to GAP, counter=0.
- FSM state GAP:
  - push_button=0, counter increments.
  - After exactly GAP_T cycles low: go to IDLE and pulse done=1 in the first IDLE cycle.
- Back-to-back commands: with cmd_valid held high, the next accept happens in the same cycle done pulses. The next press starts the following cycle, so the minimum low time between presses is GAP_T+1 cycles.
- cmd_abort:
  - In PRESS: push_button goes to 0 next cycle, go to GAP with counter=0. The full GAP and the done pulse still occur.
  - In IDLE or GAP: ignored.
  - Abort in the same cycle as accept: abort ignored, accept proceeds.
- cmd_valid while busy: ignored, no queuing. The requester holds cmd_valid until accepted.
- Counter: CNT_W bits. It cannot wrap because of the elaboration check; a compare uses counter == limit-1.
- busy = (state != IDLE). cmd_ready = ~busy. Both are driven combinationally from the registered state.

Optional Feature:
- PRESS_BOUNCE_EN defined:
  - The first 16 cycles of every PRESS window drive push_button = lfsr[0]. Cycles 17 to HOLD drive 1. The last cycle is always 1.
  - The LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset.
  - It advances only during bounce cycles and is not reseeded between commands.
  - Hold duration is unchanged: bounce cycles count toward HOLD.
- PRESS_BOUNCE_EN undefined: push_button is a clean high for all HOLD cycles and no LFSR logic exists.

Test Plan:
- Short press: reset released, cmd_valid=1 with cmd_long=0 for one cycle at edge T -> push_button high from T+1 to T+1000 inclusive, low for 20 cycles, done pulse at T+1021, cmd_ready low from T+1 to T+1020.
- Long press into the classifier instance: cmd_long=1 -> push_button high for 6000 cycles; classifier outputs an A pulse and no B pulse.
- Back-to-back: cmd_valid held high with 3 short commands -> exactly 3 presses, each 1000 high; successive rising edges of push_button are 1021 cycles apart; 3 done pulses.
- Abort: long press, cmd_abort=1 at PRESS cycle 400 -> push_button low from cycle 401, then 20-cycle gap, then done pulse. The classifier sees a B pulse (400 >= 300).
- Reset mid-press: rst=0 at PRESS cycle 50 (between clock edges) -> push_button=0 within the same cycle, busy=0, cmd_ready=1 once rst is released, no done pulse.
- PRESS_BOUNCE_EN: short press from reset -> first 16 push_button cycles equal the LFSR bits from seed ACE1, cycles 17 to 1000 high; the classifier still emits exactly one B pulse.
